dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single DATA_MEMORY port between the MIPS core's load/store path and a debug/loader requester.
- Sits between mips_single_cycle (DM_WE/DM_D/DM_ADDR/DM_Q) and DATA_MEMORY.
- The CPU has priority. A starvation counter guarantees the debug port forward progress. The debug port can lock the memory for bursts, bounded by a timeout.
- Drives cpu_stall, which freezes the core's PC and register writeback while the CPU is denied.

Parameters:
ADDR_W, 16, memory address width (matches DM_ADDR)
DATA_W, 32, memory data width
STARVE_LIMIT, 4, consecutive denied debug cycles before debug is forced a slot; legal range 1..255
MAX_LOCK, 16, maximum consecutive locked debug grants while cpu_req is high; legal range 1..255

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  core requests a memory access this cycle (load or store)
cpu_we  in  1  core access is a write
cpu_addr  in  ADDR_W  core address
cpu_d  in  DATA_W  core write data
cpu_q  out  DATA_W  read data to core (dm_q passthrough)
cpu_stall  out  1  core access denied this cycle; core must hold state
dbg_req  in  1  debug requests an access
dbg_we  in  1  debug access is a write
dbg_lock  in  1  debug keeps ownership after this grant (burst)
dbg_addr  in  ADDR_W  debug address
dbg_d  in  DATA_W  debug write data
dbg_q  out  DATA_W  read data to debug (dm_q passthrough)
dbg_ack  out  1  debug access performed this cycle; dbg_q valid this cycle for reads
dm_we  out  1  to DATA_MEMORY WE
dm_addr  out  ADDR_W  to DATA_MEMORY ADDR
dm_d  out  DATA_W  to DATA_MEMORY D
dm_q  in  DATA_W  from DATA_MEMORY Q (combinational read)
stall_cnt  out  32  count of cycles with cpu_stall=1; saturates at all-ones
force_cnt  out  16  count of starvation-forced debug grants; saturates

Behaviour:
- Memory model: read is combinational on dm_addr; write occurs at posedge when dm_we=1. Every access therefore completes in one cycle, and grant is decided combinationally each cycle from the inputs and registered state.
- FSM states: ST_SHARED and ST_LOCKED. Registers: wait_cnt[7:0], lock_cnt[7:0], stall_cnt, force_cnt.
- Grant in ST_SHARED:
  - Only cpu_req: CPU granted.
  - Only dbg_req: debug granted.
  - Both requesting: CPU granted, unless wait_cnt == STARVE_LIMIT; then debug is granted and force_cnt increments.
- Grant in ST_LOCKED:
  - Debug granted when dbg_req=1.
  - If dbg_req=0, CPU granted when cpu_req=1.
  - If cpu_req=1 and lock_cnt == MAX_LOCK, CPU is granted instead (forced release).
- Outputs under grant:
  - CPU grant: dm_* = cpu_*; dm_we = cpu_we.
  - Debug grant: dm_* = dbg_*; dm_we = dbg_we; dbg_ack=1.
  - No grant: dm_we=0; dm_addr and dm_d = CPU values.
- cpu_stall = cpu_req & ~cpu_granted.
- cpu_q and dbg_q both equal dm_q; they are meaningful only to the granted side.
- Transitions:
  - ST_SHARED -> ST_LOCKED: debug granted with dbg_lock=1.
  - ST_LOCKED -> ST_SHARED: any of (a) a debug grant with dbg_lock=0, (b) dbg_req=0, (c) forced release.
- wait_cnt:
  - Increments (saturating at STARVE_LIMIT) when dbg_req=1 and debug is not granted.
  - Clears on any debug grant or when dbg_req=0.
- lock_cnt:
  - Increments when in ST_LOCKED, debug granted and cpu_req=1.
  - Clears on leaving ST_LOCKED, or on any cycle with cpu_req=0.
- Forced release sets wait_cnt to 0. Debug re-arbitrates normally from there.
- Reset: state=ST_SHARED; wait_cnt, lock_cnt, stall_cnt and force_cnt all 0.
- Reset takes priority over all events. During a cycle with rst=1:
  - dm_we=0, dbg_ack=0, cpu_stall=0.
  - A lock in progress is dropped with no write performed.
- Simultaneous requests with wait_cnt reaching STARVE_LIMIT on the same cycle: the new value applies only from the next cycle.
- No combinational path from dm_q to any control output.

Decomposition:
- Shared package func_pkg gains:
  - enum arb_state_t {ST_SHARED, ST_LOCKED}.
  - typedef struct mem_req_t {we, addr, d}, used for both requesters.
  - Constants DM_ADDR_W=16 and DM_DATA_W=32.
- One natural sub-module, sat_counter (parameterised width, inc/clr, saturating), instantiated for wait_cnt, lock_cnt, stall_cnt and force_cnt.

Test Plan:
- CPU alone: cpu_req=1, we=1, addr=0x0002, d=0x5 for one cycle; then a read of 0x0002 -> cpu_q=0x5, cpu_stall=0 throughout, stall_cnt=0.
- Starvation: both requesting continuously, STARVE_LIMIT=4 -> CPU granted cycles 0-3, debug granted cycle 4 (dbg_ack=1, cpu_stall=1), force_cnt=1, pattern repeats with period 5.
- Lock burst: debug writes 0x10..0x13 with dbg_lock=1, cpu_req=0 -> 4 consecutive dbg_ack, state returns to ST_SHARED after the dbg_lock=0 beat, memory holds the 4 values.
- Lock timeout: MAX_LOCK=16, dbg_lock=1 and cpu_req=1 held -> 16 debug grants, CPU granted on cycle 17, stall_cnt=16.
- Reset mid-lock: assert rst in 3rd locked beat with dbg_we=1 -> that address unchanged, dbg_ack=0, next cycle ST_SHARED, all counters 0.
- Debug alone after reset: dbg_req=1, read 0x0002 -> dbg_ack=1 same cycle, dbg_q=0x5, wait_cnt stays 0.

Source files
------------

// File: rtl/func_pkg.sv
// Shared data-memory types: arbiter FSM states, request bundle and bus widths.
package func_pkg;

  localparam int unsigned DM_ADDR_W = 16;
  localparam int unsigned DM_DATA_W = 32;

  typedef enum logic [0:0] {
    ST_SHARED,
    ST_LOCKED
  } arb_state_t;

  typedef struct packed {
    logic                 we;
    logic [DM_ADDR_W-1:0] addr;
    logic [DM_DATA_W-1:0] d;
  } mem_req_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the core port, the debug/loader port and the DATA_MEMORY port.
interface dm_arbiter_if
  import func_pkg::*;
#(
  parameter int unsigned ADDR_W = DM_ADDR_W,
  parameter int unsigned DATA_W = DM_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_d;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_d;
  logic [DATA_W-1:0] dbg_q;
  logic              dbg_ack;

  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_d;
  logic [DATA_W-1:0] dm_q;

  // Requesters and memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_d,
    input  cpu_q, cpu_stall,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_d,
    input  dbg_q, dbg_ack,
    input  dm_we, dm_addr, dm_d,
    output dm_q
  );

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_d,
    output cpu_q, cpu_stall,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_d,
    output dbg_q, dbg_ack,
    output dm_we, dm_addr, dm_d,
    input  dm_q
  );

endinterface

// File: rtl/dm_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
module sat_counter #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dm_arbiter.sv
// Single-port DATA_MEMORY arbiter: CPU priority, starvation-forced debug slots,
// and debug burst locking bounded by a lock timeout.
module dm_arbiter
  import func_pkg::*;
#(
  parameter int unsigned ADDR_W       = DM_ADDR_W,
  parameter int unsigned DATA_W       = DM_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_LOCK     = 16
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  bus,
  output logic [31:0]  stall_cnt,
  output logic [15:0]  force_cnt
);

  arb_state_t state_q, state_d;
  logic [7:0] wait_cnt;
  logic [7:0] lock_cnt;

  mem_req_t cpu_r, dbg_r, dm_r;
  logic     cpu_gnt, dbg_gnt, force_gnt, forced_rel;
  logic     starve, lock_expired, leave_lock;

  assign cpu_r = '{we: bus.cpu_we, addr: bus.cpu_addr, d: bus.cpu_d};
  assign dbg_r = '{we: bus.dbg_we, addr: bus.dbg_addr, d: bus.dbg_d};

  // Decided from registered counters only, so dm_q never reaches control.
  assign starve       = (wait_cnt == 8'(STARVE_LIMIT));
  assign lock_expired = (lock_cnt == 8'(MAX_LOCK));

  always_comb begin
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    force_gnt  = 1'b0;
    forced_rel = 1'b0;
    state_d    = state_q;

    unique case (state_q)
      ST_SHARED: begin
        if (bus.dbg_req && (!bus.cpu_req || starve)) begin
          dbg_gnt   = 1'b1;
          force_gnt = bus.cpu_req;
        end else begin
          cpu_gnt = bus.cpu_req;
        end
        if (dbg_gnt && bus.dbg_lock) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (bus.cpu_req && lock_expired) begin
          cpu_gnt    = 1'b1;
          forced_rel = 1'b1;
        end else if (bus.dbg_req) begin
          dbg_gnt = 1'b1;
        end else begin
          cpu_gnt = bus.cpu_req;
        end
        if (forced_rel || !bus.dbg_req || (dbg_gnt && !bus.dbg_lock)) begin
          state_d = ST_SHARED;
        end
      end
      default: state_d = ST_SHARED;
    endcase

    // Reset cycle: nobody is granted, so no write and no stall.
    if (rst) begin
      cpu_gnt    = 1'b0;
      dbg_gnt    = 1'b0;
      force_gnt  = 1'b0;
      forced_rel = 1'b0;
      state_d    = ST_SHARED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SHARED;
    end else begin
      state_q <= state_d;
    end
  end

  assign dm_r          = dbg_gnt ? dbg_r : cpu_r;
  assign bus.dm_we     = (cpu_gnt || dbg_gnt) && dm_r.we;
  assign bus.dm_addr   = dm_r.addr;
  assign bus.dm_d      = dm_r.d;
  assign bus.dbg_ack   = dbg_gnt;
  assign bus.cpu_stall = bus.cpu_req && !cpu_gnt && !rst;
  assign bus.cpu_q     = bus.dm_q;
  assign bus.dbg_q     = bus.dm_q;

  assign leave_lock = (state_q == ST_LOCKED) && (state_d == ST_SHARED);

  sat_counter #(
    .WIDTH (8),
    .MAX   (8'(STARVE_LIMIT))
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bus.dbg_req && !dbg_gnt),
    .clr (dbg_gnt || !bus.dbg_req || forced_rel),
    .cnt (wait_cnt)
  );

  sat_counter #(
    .WIDTH (8),
    .MAX   (8'hff)
  ) u_lock_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((state_q == ST_LOCKED) && dbg_gnt && bus.cpu_req),
    .clr (!bus.cpu_req || leave_lock),
    .cnt (lock_cnt)
  );

  sat_counter #(
    .WIDTH (32),
    .MAX   ('1)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bus.cpu_stall),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

  sat_counter #(
    .WIDTH (16),
    .MAX   ('1)
  ) u_force_cnt (
    .clk (clk),
    .rst (rst),
    .inc (force_gnt),
    .clr (1'b0),
    .cnt (force_cnt)
  );

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural combinational-read data memory.
module tb_dm_arbiter;
  import func_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] stall_cnt;
  logic [15:0] force_cnt;

  dm_arbiter_if bus ();

  dm_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (32),
    .STARVE_LIMIT (4),
    .MAX_LOCK     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .force_cnt (force_cnt)
  );

  logic [31:0] mem [256];
  assign bus.dm_q = mem[bus.dm_addr[7:0]];
  always @(posedge clk) begin
    if (bus.dm_we) mem[bus.dm_addr[7:0]] <= bus.dm_d;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_drv(input logic req, input logic we, input logic [15:0] addr,
                         input logic [31:0] d);
    bus.cpu_req  = req;
    bus.cpu_we   = we;
    bus.cpu_addr = addr;
    bus.cpu_d    = d;
  endtask

  task automatic dbg_drv(input logic req, input logic we, input logic lock,
                         input logic [15:0] addr, input logic [31:0] d);
    bus.dbg_req  = req;
    bus.dbg_we   = we;
    bus.dbg_lock = lock;
    bus.dbg_addr = addr;
    bus.dbg_d    = d;
  endtask

  // Advance to the next negedge (drive point); checks follow #1 later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cpu_drv(1'b1, 1'b1, 16'h0030, 32'h0);
    dbg_drv(1'b1, 1'b1, 1'b1, 16'h0031, 32'hff);

    // Reset: requests present but nothing granted.
    step(); #1;
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_ack", 32'(bus.dbg_ack), 32'd0);
    chk("rst_we", 32'(bus.dm_we), 32'd0);
    step();
    rst = 1'b0;
    cpu_drv(1'b0, 1'b0, 16'h0, 32'h0);
    dbg_drv(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_force_cnt", 32'(force_cnt), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_SHARED));

    // CPU alone: write 0x0002 <= 5, then read it back.
    step(); cpu_drv(1'b1, 1'b1, 16'h0002, 32'h5); #1;
    chk("cpu_wr_stall", 32'(bus.cpu_stall), 32'd0);
    chk("cpu_wr_we", 32'(bus.dm_we), 32'd1);
    step(); cpu_drv(1'b1, 1'b0, 16'h0002, 32'h0); #1;
    chk("cpu_rd_q", bus.cpu_q, 32'h5);
    chk("cpu_rd_stall", 32'(bus.cpu_stall), 32'd0);
    step(); cpu_drv(1'b0, 1'b0, 16'h0, 32'h0); #1;
    chk("cpu_stall_cnt", stall_cnt, 32'd0);

    // Starvation: both requesting, debug forced every 5th cycle.
    for (int i = 0; i < 10; i++) begin
      step();
      cpu_drv(1'b1, 1'b0, 16'h0003, 32'h0);
      dbg_drv(1'b1, 1'b0, 1'b0, 16'h0004, 32'h0);
      #1;
      chk($sformatf("starve_ack%0d", i), 32'(bus.dbg_ack), 32'((i % 5) == 4));
      chk($sformatf("starve_stall%0d", i), 32'(bus.cpu_stall), 32'((i % 5) == 4));
      chk($sformatf("starve_fcnt%0d", i), 32'(force_cnt), (i >= 5) ? 32'd1 : 32'd0);
    end
    step();
    cpu_drv(1'b0, 1'b0, 16'h0, 32'h0);
    dbg_drv(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    chk("starve_fcnt_end", 32'(force_cnt), 32'd2);
    chk("starve_scnt_end", stall_cnt, 32'd2);

    // Lock burst: four locked debug writes, CPU idle.
    for (int i = 0; i < 4; i++) begin
      step();
      dbg_drv(1'b1, 1'b1, (i < 3), 16'(16'h0010 + i), 32'(32'ha0 + i));
      #1;
      chk($sformatf("burst_ack%0d", i), 32'(bus.dbg_ack), 32'd1);
      if (i == 1) chk("burst_locked", 32'(dut.state_q), 32'(ST_LOCKED));
    end
    step(); dbg_drv(1'b0, 1'b0, 1'b0, 16'h0, 32'h0); #1;
    chk("burst_state", 32'(dut.state_q), 32'(ST_SHARED));
    for (int i = 0; i < 4; i++) begin
      step(); dbg_drv(1'b1, 1'b0, 1'b0, 16'(16'h0010 + i), 32'h0); #1;
      chk($sformatf("burst_rd%0d", i), bus.dbg_q, 32'(32'ha0 + i));
    end

    // Lock timeout: fresh counters, enter lock with CPU idle, then CPU requests.
    step(); rst = 1'b1; dbg_drv(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    step(); rst = 1'b0; dbg_drv(1'b1, 1'b0, 1'b1, 16'h0010, 32'h0); #1;
    chk("lt_enter_ack", 32'(bus.dbg_ack), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(); cpu_drv(1'b1, 1'b0, 16'h0002, 32'h0); #1;
      chk($sformatf("lt_ack%0d", i), 32'(bus.dbg_ack), 32'd1);
      chk($sformatf("lt_stall%0d", i), 32'(bus.cpu_stall), 32'd1);
    end
    step(); #1;
    chk("lt_rel_ack", 32'(bus.dbg_ack), 32'd0);
    chk("lt_rel_stall", 32'(bus.cpu_stall), 32'd0);
    chk("lt_rel_q", bus.cpu_q, 32'h5);
    step(); #1;
    chk("lt_scnt", stall_cnt, 32'd16);
    chk("lt_state", 32'(dut.state_q), 32'(ST_SHARED));
    chk("lt_after_stall", 32'(bus.cpu_stall), 32'd0);
    step();
    cpu_drv(1'b0, 1'b0, 16'h0, 32'h0);
    dbg_drv(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);

    // Reset mid-lock: third locked write is dropped.
    step(); cpu_drv(1'b1, 1'b1, 16'h0022, 32'h77);
    step(); cpu_drv(1'b0, 1'b0, 16'h0, 32'h0); dbg_drv(1'b1, 1'b1, 1'b1, 16'h0020, 32'h1);
    step(); dbg_drv(1'b1, 1'b1, 1'b1, 16'h0021, 32'h2);
    step(); rst = 1'b1; dbg_drv(1'b1, 1'b1, 1'b1, 16'h0022, 32'hdead); #1;
    chk("rl_ack", 32'(bus.dbg_ack), 32'd0);
    chk("rl_we", 32'(bus.dm_we), 32'd0);
    step(); rst = 1'b0; dbg_drv(1'b0, 1'b0, 1'b0, 16'h0, 32'h0); #1;
    chk("rl_state", 32'(dut.state_q), 32'(ST_SHARED));
    chk("rl_wait", 32'(dut.wait_cnt), 32'd0);
    chk("rl_lock", 32'(dut.lock_cnt), 32'd0);
    chk("rl_scnt", stall_cnt, 32'd0);
    chk("rl_fcnt", 32'(force_cnt), 32'd0);
    step(); cpu_drv(1'b1, 1'b0, 16'h0022, 32'h0); #1;
    chk("rl_kept", bus.cpu_q, 32'h77);
    step(); cpu_drv(1'b1, 1'b0, 16'h0020, 32'h0); #1;
    chk("rl_beat0", bus.cpu_q, 32'h1);

    // Debug alone: same-cycle ack and read data.
    step(); cpu_drv(1'b0, 1'b0, 16'h0, 32'h0); dbg_drv(1'b1, 1'b0, 1'b0, 16'h0002, 32'h0); #1;
    chk("dbg_ack", 32'(bus.dbg_ack), 32'd1);
    chk("dbg_q", bus.dbg_q, 32'h5);
    step(); dbg_drv(1'b0, 1'b0, 1'b0, 16'h0, 32'h0); #1;
    chk("dbg_wait", 32'(dut.wait_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
